// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, bus geometry
// and the request address error check.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int BE_WIDTH   = 4;
  localparam int WORD_BYTES = 4;

  // A request is in error if it is not word aligned or if any byte-address bit
  // above the implemented word index is set.
  function automatic logic addr_err(input logic [31:0] addr, input int aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage and the data-memory responder.
//
// Handshake: a channel transfers on a rising clk edge where its valid and
// ready are both high. valid must not depend on ready; once raised, the
// responder holds rsp_valid and every rsp_* field stable until rsp_ready.
// req_ready depends only on responder state, never on req_valid.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [31:0]         req_addr;
  logic [31:0]         req_wdata;
  logic [BE_WIDTH-1:0] req_be;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array_be.sv
// Single-port synchronous word array with per-byte write enables. The read
// register only updates when re is high, so a captured load word stays put
// while the response waits for the consumer.
module dmem_array_be
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [BE_WIDTH-1:0]   we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Byte-lane writes and enabled word read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, waits WAIT_CYCLES,
// performs the access and presents the result until the consumer takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 10,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = "dmem.hex"
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output state_t            dbg_state
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state, state_next;
  logic [3:0]          wait_cnt;

  logic                lat_we;
  logic [31:0]         lat_addr;
  logic [31:0]         lat_wdata;
  logic [BE_WIDTH-1:0] lat_be;

  logic                cur_we;
  logic [31:0]         cur_addr;
  logic [31:0]         cur_wdata;
  logic [BE_WIDTH-1:0] cur_be;
  logic                cur_err;

  logic                accept;
  logic                commit;
  logic                rsp_hs;
  logic                rsp_err_q;
  logic                rsp_load_q;

  logic [BE_WIDTH-1:0] arr_we;
  logic                arr_re;
  logic [31:0]         arr_rdata;

  assign bus.req_ready = (state == ST_IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign rsp_hs        = (state == ST_RESP) && bus.rsp_ready;
  assign dbg_state     = state;

  // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (wait_cnt == 4'd0) state_next = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // With zero wait states the access commits on the accept edge itself, so
  // the live request is used instead of the not-yet-latched copy.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_be    = lat_be;
    if (state == ST_IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
    end
  end

  // Commit on the edge that enters RESP; reset suppresses any pending write.
  assign commit  = !rst && (state != ST_RESP) && (state_next == ST_RESP);
  assign cur_err = addr_err(cur_addr, ADDR_WIDTH);
  assign arr_we  = (commit && cur_we && !cur_err) ? cur_be : '0;
  assign arr_re  = commit && !cur_we && !cur_err;

  dmem_array_be #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (cur_addr[ADDR_WIDTH+1:2]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Wait-state counter: loaded on accept, counts down while in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     wait_cnt <= 4'd0;
    else if (accept)                             wait_cnt <= WAIT_INIT;
    else if (state == ST_WAIT && wait_cnt != 0)  wait_cnt <= wait_cnt - 4'd1;
  end

  // Request latch, captured on the accept handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      lat_we    <= bus.req_we;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
      lat_be    <= bus.req_be;
    end
  end

  // Response flags: set at commit, cleared when the response is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else if (commit) begin
      rsp_err_q  <= cur_err;
      rsp_load_q <= !cur_we && !cur_err;
    end else if (rsp_hs) begin
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rsp_load_q ? arr_rdata : 32'd0;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with one wait state and one with
// four, driven one transaction at a time against a word-array model.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg1, dbg4;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];
  logic [31:0] mem_m [2][1024];

  dmem_responder_if bus1 ();
  dmem_responder_if bus4 ();

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1), .INIT_FILE("")) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1)
  );
  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(4), .INIT_FILE("")) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .dbg_state(dbg4)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic        rdy(input int s);   return s != 0 ? bus4.req_ready : bus1.req_ready; endfunction
  function automatic logic        vld(input int s);   return s != 0 ? bus4.rsp_valid : bus1.rsp_valid; endfunction
  function automatic logic [31:0] rdat(input int s);  return s != 0 ? bus4.rsp_rdata : bus1.rsp_rdata; endfunction
  function automatic logic        rerr(input int s);  return s != 0 ? bus4.rsp_err   : bus1.rsp_err;   endfunction
  function automatic state_t      dstate(input int s); return s != 0 ? dbg4 : dbg1; endfunction

  // Driver tasks.
  task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
    bus1.req_we = we; bus1.req_addr = addr; bus1.req_wdata = wdata; bus1.req_be = be;
    bus4.req_we = we; bus4.req_addr = addr; bus4.req_wdata = wdata; bus4.req_be = be;
  endtask

  task automatic set_valid(input int s, input logic v);
    if (s != 0) bus4.req_valid = v;
    else        bus1.req_valid = v;
  endtask

  task automatic scramble_req();
    set_req(1'($urandom), $urandom, $urandom, 4'($urandom));
  endtask

  // Reference model: word array with byte-lane stores; misaligned or
  // beyond-depth byte addresses are errors with no side effect.
  task automatic model_issue(input int s, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
    bit          bad;
    int          idx;
    logic [31:0] word;
    bad = (addr % 4 != 0) || (addr >= 32'd4096);
    idx = int'(addr / 4) % 1024;
    if (bad) begin
      exp_q.push_back({1'b1, 32'd0});
    end else if (we) begin
      word = mem_m[s][idx];
      for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
      mem_m[s][idx] = word;
      exp_q.push_back({1'b0, 32'd0});
    end else begin
      exp_q.push_back({1'b0, mem_m[s][idx]});
    end
  endtask

  // One full transaction; starts and ends just after a falling edge.
  task automatic do_txn(input int s, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold);
    int          n;
    int          w;
    logic [32:0] exp;
    w = (s != 0) ? 4 : 1;
    model_issue(s, we, addr, wdata, be);
    set_req(we, addr, wdata, be);
    set_valid(s, 1'b1);
    n = 0;
    while (!rdy(s) && n < 20) begin @(negedge clk); n++; end
    check("req_ready_wait", 64'(rdy(s)), 64'd1);
    @(negedge clk);
    set_valid(s, 1'b0);
    scramble_req();
    n = 0;
    while (!vld(s) && n < 40) begin @(negedge clk); n++; end
    check("latency", 64'(n), 64'(w));
    exp = exp_q.pop_front();
    check("rsp_err", 64'(rerr(s)), 64'(exp[32]));
    check("rsp_rdata", 64'(rdat(s)), 64'(exp[31:0]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(vld(s)), 64'd1);
      check("bp_rdata", 64'(rdat(s)), 64'(exp[31:0]));
      check("bp_err", 64'(rerr(s)), 64'(exp[32]));
      check("bp_req_ready", 64'(rdy(s)), 64'd0);
    end
    bus1.rsp_ready = 1'b1;
    bus4.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    bus4.rsp_ready = 1'b0;
    check("post_req_ready", 64'(rdy(s)), 64'd1);
    check("post_valid", 64'(vld(s)), 64'd0);
    check("post_rdata", 64'(rdat(s)), 64'd0);
    check("post_err", 64'(rerr(s)), 64'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 15) * 4);
    else if (r == 7) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    else             return (32'($urandom_range(1, 1048575)) << 12) | 32'($urandom_range(0, 1023) * 4);
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    bus1.req_valid = 1'b0; bus4.req_valid = 1'b0;
    bus1.rsp_ready = 1'b0; bus4.rsp_ready = 1'b0;
    set_req(1'b0, 32'd0, 32'd0, 4'd0);

    // Reset state.
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_valid", 64'(vld(s)), 64'd0);
      check("rst_rdata", 64'(rdat(s)), 64'd0);
      check("rst_err", 64'(rerr(s)), 64'd0);
      check("rst_req_ready", 64'(rdy(s)), 64'd0);
      check("rst_state", 64'(dstate(s)), 64'(ST_IDLE));
    end
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready1", 64'(rdy(0)), 64'd1);
    check("idle_ready4", 64'(rdy(1)), 64'd1);

    // Give every word in the working set a known value.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        do_txn(s, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);

    // Store/load, byte merge, empty byte mask, errors.
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    do_txn(0, 1'b1, 32'h10, 32'h00001200, 4'b0010, 0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    check("merge_value", 64'(mem_m[0][4]), 64'h00000000_DEAD12EF);
    do_txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    do_txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0);
    do_txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 0);
    do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    do_txn(1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'b1001, 0);
    do_txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 0);

    // Backpressure in RESP.
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
    do_txn(1, 1'b0, 32'h1F, 32'h0, 4'h0, 5);

    // Randomized traffic across both instances.
    for (int i = 0; i < 80; i++)
      do_txn(int'($urandom_range(0, 1)), 1'($urandom), rand_addr(), $urandom,
             4'($urandom), int'($urandom_range(0, 3)));

    // Reset while a store is still waiting: the write must be dropped.
    set_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    set_valid(1, 1'b1);
    @(negedge clk);
    set_valid(1, 1'b0);
    @(negedge clk);
    check("abort_in_wait", 64'(dbg4), 64'(ST_WAIT));
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("abort_state", 64'(dbg4), 64'(ST_IDLE));
    check("abort_valid", 64'(vld(1)), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(rdy(1)), 64'd1);
    do_txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0);

    // Asynchronous reset while a load response is pending.
    set_req(1'b0, 32'h10, 32'h0, 4'h0);
    set_valid(0, 1'b1);
    @(negedge clk);
    set_valid(0, 1'b0);
    n = 0;
    while (!vld(0) && n < 40) begin @(negedge clk); n++; end
    check("pend_valid", 64'(vld(0)), 64'd1);
    check("pend_rdata", 64'(rdat(0)), 64'(mem_m[0][4]));
    #2 rst = 1'b1;
    #1 check("async_valid", 64'(vld(0)), 64'd0);
    check("async_rdata", 64'(rdat(0)), 64'd0);
    check("async_err", 64'(rerr(0)), 64'd0);
    check("async_ready", 64'(rdy(0)), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("async_ready_after", 64'(rdy(0)), 64'd1);
    check("async_state", 64'(dbg1), 64'(ST_IDLE));
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
